fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 31 +++
 rtl/fetch_sequencer_pc_reg.sv | 25 ++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions for the fetch sequencer: state encoding, vector
// defaults and small PC helpers used by the top level.
package fetch_sequencer_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_BOOT   = 2'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 2'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE  = 2'd2;
    localparam logic [STATE_W-1:0] ST_HALTED = 2'd3;

    // Source selected for the next PC value when an instruction is consumed.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_SEQ      = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_TRAP     = 2'd3
    } pc_sel_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic target_misaligned(input logic [31:0] target);
        return |target[1:0];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// 32-bit program counter register with load enable and asynchronous
// active-low reset to a parameterised value.
module pc_reg #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q <= RESET_VALUE;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches one word at a time, presents it to
// decode, and resolves halt/trap/redirect/sequential flow on consume.
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic        clk_core_i,
    input  logic        rst_core_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        trap_i,
    input  logic        halt_i,
    output logic        trap_taken_o,
    output logic        halted_o,
    output logic [31:0] retired_count_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        instr_pc_q, instr_pc_d;
    logic               trap_taken_q, trap_taken_d;
    logic [31:0]        retired_q, retired_d;

    pc_sel_e            pc_sel;
    logic               pc_load;
    logic [31:0]        pc_next;
    logic [31:0]        pc_q;

    pc_reg #(
        .RESET_VALUE(RESET_VECTOR)
    ) u_pc_reg (
        .clk_i  (clk_core_i),
        .rst_n_i(rst_core_n_i),
        .load_i (pc_load),
        .d_i    (pc_next),
        .q_o    (pc_q)
    );

    // Acks are only sampled in FETCH, so a late ack from a request issued
    // before reset lands in BOOT and is dropped.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        trap_taken_d = 1'b0;
        retired_d    = retired_q;
        pc_sel       = PC_HOLD;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (imem_ack_i) begin
                    instr_d    = imem_data_i;
                    instr_pc_d = pc_q;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!stall_i) begin
                    retired_d = retired_q + 32'd1;
                    if (halt_i) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                        if (trap_i || (redirect_i && target_misaligned(redirect_target_i))) begin
                            pc_sel       = PC_TRAP;
                            trap_taken_d = 1'b1;
                        end else if (redirect_i) begin
                            pc_sel = PC_REDIRECT;
                        end else begin
                            pc_sel = PC_SEQ;
                        end
                    end
                end
            end

            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        pc_load = (pc_sel != PC_HOLD);
        case (pc_sel)
            PC_SEQ:      pc_next = seq_pc(pc_q);
            PC_REDIRECT: pc_next = redirect_target_i;
            PC_TRAP:     pc_next = TRAP_VECTOR;
            default:     pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk_core_i or negedge rst_core_n_i) begin
        if (!rst_core_n_i) begin
            state_q      <= ST_BOOT;
            instr_q      <= 32'h0;
            instr_pc_q   <= 32'h0;
            trap_taken_q <= 1'b0;
            retired_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            trap_taken_q <= trap_taken_d;
            retired_q    <= retired_d;
        end
    end

    assign imem_req_o      = (state_q == ST_FETCH);
    assign imem_addr_o     = pc_q;
    assign instr_valid_o   = (state_q == ST_ISSUE);
    assign instr_o         = instr_q;
    assign instr_pc_o      = instr_pc_q;
    assign trap_taken_o    = trap_taken_q;
    assign halted_o        = (state_q == ST_HALTED);
    assign retired_count_o = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap = 1'b0;
    logic        halt = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        trap_taken;
    logic        halted;
    logic [31:0] retired;

    fetch_sequencer dut (
        .clk_core_i       (clk),
        .rst_core_n_i     (rst_n),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ack_i       (imem_ack),
        .imem_data_i      (imem_data),
        .instr_valid_o    (instr_valid),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .stall_i          (stall),
        .redirect_i       (redirect),
        .redirect_target_i(redirect_target),
        .trap_i           (trap),
        .halt_i           (halt),
        .trap_taken_o     (trap_taken),
        .halted_o         (halted),
        .retired_count_o  (retired)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: which phase the core is in, plus the architectural values.
    bit          m_boot, m_fetch, m_issue, m_halted, m_pulse;
    logic [31:0] m_pc, m_instr, m_instr_pc, m_retired;

    function automatic void model_reset();
        m_boot = 1'b1; m_fetch = 1'b0; m_issue = 1'b0; m_halted = 1'b0; m_pulse = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_instr_pc = 32'h0; m_retired = 32'h0;
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            m_pulse = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0;
                m_fetch = 1'b1;
            end else if (m_fetch) begin
                if (imem_ack) begin
                    m_instr = imem_data;
                    m_instr_pc = m_pc;
                    m_fetch = 1'b0;
                    m_issue = 1'b1;
                end
            end else if (m_issue && !stall) begin
                m_retired = m_retired + 32'd1;
                m_issue = 1'b0;
                if (halt) begin
                    m_halted = 1'b1;
                end else begin
                    m_fetch = 1'b1;
                    if (trap || (redirect && (redirect_target % 4 != 0))) begin
                        m_pc = TRAP_VEC;
                        m_pulse = 1'b1;
                    end else if (redirect) begin
                        m_pc = redirect_target;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.imem_req", imem_req, m_fetch);
            chk("m.imem_addr", imem_addr, m_pc);
            chk("m.instr_valid", instr_valid, m_issue);
            chk("m.instr", instr, m_instr);
            chk("m.instr_pc", instr_pc, m_instr_pc);
            chk("m.trap_taken", trap_taken, m_pulse);
            chk("m.halted", halted, m_halted);
            chk("m.retired", retired, m_retired);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        trap = 1'b0; halt = 1'b0; redirect_target = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.imem_req", imem_req, 32'd0);
        chk("rst.imem_addr", imem_addr, 32'h0);
        chk("rst.instr_valid", instr_valid, 32'd0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.instr_pc", instr_pc, 32'h0);
        chk("rst.trap_taken", trap_taken, 32'd0);
        chk("rst.halted", halted, 32'd0);
        chk("rst.retired", retired, 32'h0);
        step();
        rst_n = 1'b1;
    endtask

    // Fetch one instruction (ack on the second FETCH cycle), hold it for
    // 'stalls' cycles with noise on the control inputs, then consume it.
    task automatic do_instr(input string tag, input logic [31:0] exp_addr, input logic [31:0] data,
                            input int stalls, input bit rd, input logic [31:0] tg,
                            input bit tr, input bit hl, input logic [31:0] exp_ret);
        chk({tag, ".req"}, imem_req, 32'd1);
        chk({tag, ".addr"}, imem_addr, exp_addr);
        idle_inputs();
        step();
        chk({tag, ".addr_hold"}, imem_addr, exp_addr);
        imem_ack = 1'b1; imem_data = data;
        step();
        imem_ack = 1'b0; imem_data = $urandom;
        chk({tag, ".valid"}, instr_valid, 32'd1);
        chk({tag, ".instr"}, instr, data);
        chk({tag, ".instr_pc"}, instr_pc, exp_addr);
        for (int s = 0; s < stalls; s++) begin
            stall = 1'b1; redirect = 1'($urandom); trap = 1'($urandom);
            halt = 1'($urandom); redirect_target = $urandom;
            step();
            chk({tag, ".stall_req"}, imem_req, 32'd0);
            chk({tag, ".stall_instr"}, instr, data);
            chk({tag, ".stall_pc"}, instr_pc, exp_addr);
            chk({tag, ".stall_ret"}, retired, exp_ret - 32'd1);
        end
        stall = 1'b0; redirect = rd; redirect_target = tg; trap = tr; halt = hl;
        step();
        idle_inputs();
        chk({tag, ".retired"}, retired, exp_ret);
        $display("txn %s pc=%h instr=%h stalls=%0d retired=%0d", tag, exp_addr, data, stalls, retired);
    endtask

    int halted_cycles = 0;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        step();
        cmp_en = 1'b1;

        do_reset();
        step();
        do_instr("seq0", 32'h0, 32'h0000_0013, 0, 0, 0, 0, 0, 32'd1);
        do_instr("seq1", 32'h4, 32'h0010_0093, 0, 0, 0, 0, 0, 32'd2);
        do_instr("seq2", 32'h8, 32'h0020_0113, 0, 0, 0, 0, 0, 32'd3);
        chk("seq.retired3", retired, 32'd3);
        do_instr("stall3", 32'hC, 32'h0030_0193, 3, 0, 0, 0, 0, 32'd4);
        do_instr("redir", 32'h10, 32'h2000_006F, 0, 1, 32'h200, 0, 0, 32'd5);
        do_instr("misal", 32'h200, 32'h0020_006F, 0, 1, 32'h202, 0, 0, 32'd6);
        chk("misal.trap_taken", trap_taken, 32'd1);
        do_instr("trap_redir", 32'h100, 32'h0000_0073, 1, 1, 32'h400, 1, 0, 32'd7);
        chk("trap_redir.trap_taken", trap_taken, 32'd1);
        do_instr("halt_trap", 32'h100, 32'h0010_0073, 0, 0, 0, 1, 1, 32'd8);
        chk("halt.halted", halted, 32'd1);
        chk("halt.trap_taken", trap_taken, 32'd0);
        imem_ack = 1'b1; step(); step(); imem_ack = 1'b0;
        chk("halt.frozen_ret", retired, 32'd8);
        chk("halt.frozen_addr", imem_addr, 32'h100);
        chk("halt.no_req", imem_req, 32'd0);

        do_reset();
        step();
        do_instr("wrapA", 32'h0, 32'hFE00_0EE3, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'd1);
        do_instr("wrapB", 32'hFFFF_FFFC, 32'h0000_0013, 0, 0, 0, 0, 0, 32'd2);
        do_instr("wrapC", 32'h0, 32'h0000_0013, 0, 0, 0, 0, 0, 32'd3);

        // Reset mid-fetch with a stale ack arriving across reset and boot.
        step();
        chk("midfetch.req", imem_req, 32'd1);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        do_reset();
        step();
        chk("stale.valid", instr_valid, 32'd0);
        chk("stale.instr", instr, 32'h0);
        do_instr("fresh", 32'h0, 32'h1234_5678, 0, 0, 0, 0, 0, 32'd1);

        for (int i = 0; i < 4000; i++) begin
            imem_ack = ($urandom % 3) != 0;
            imem_data = $urandom;
            stall = ($urandom % 10) < 4;
            redirect = ($urandom % 10) < 3;
            case ($urandom % 4)
                0: redirect_target = $urandom;
                1: redirect_target = 32'hFFFF_FFFC;
                default: redirect_target = $urandom & 32'hFFFF_FFFC;
            endcase
            trap = ($urandom % 16) == 0;
            halt = ($urandom % 40) == 0;
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            if (($urandom % 300) == 0 || halted_cycles > 4) begin
                halted_cycles = 0;
                do_reset();
            end else begin
                step();
            end
        end

        idle_inputs();
        step();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
